// File: rtl/alu_mac_sequencer.sv
// alu_mac_sequencer: steps a shared combinational ALU through one neuron
// pre-activation, y = bias +/- sum(w[i]*x[i]). Each term is fetched over a
// ready/valid request port, multiplied in one cycle and accumulated in the
// next. The block only routes 16-bit words; all arithmetic lives in the ALU.
module alu_mac_sequencer #(
    parameter int N_MAX  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    num_terms,
    input  logic [DATA_W-1:0] bias,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y,
    output logic              req_valid,
    output logic [IDX_W-1:0]  req_idx,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic              alu_en,
    output logic [1:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MULT,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0]   N_MAX_L = (IDX_W+1)'(N_MAX);
    localparam logic [IDX_W:0]   ONE_N   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);
    localparam logic [1:0]       OP_ADD  = 2'b00;
    localparam logic [1:0]       OP_SUB  = 2'b01;
    localparam logic [1:0]       OP_MUL  = 2'b10;

    // Term counts above the array depth saturate at N_MAX.
    function automatic logic [IDX_W:0] clamp_terms(input logic [IDX_W:0] n);
        return (n > N_MAX_L) ? N_MAX_L : n;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W:0]      n_q, n_d;
    logic                mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   prod_q, prod_d;
    logic [DATA_W-1:0]   w_q, w_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [IDX_W:0]      n_start;
    logic                last_term;

    assign n_start   = clamp_terms(num_terms);
    assign last_term = ({1'b0, idx_q} == (n_q - ONE_N));
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign y         = y_q;

    // Next-state, datapath capture and ALU/request port drive.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        w_d        = w_q;
        x_d        = x_q;
        y_d        = y_q;
        req_valid  = 1'b0;
        req_idx    = '0;
        alu_en     = 1'b0;
        alu_op_sel = OP_ADD;
        alu_op1    = '0;
        alu_op2    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d    = n_start;
                    mode_d = mode;
                    acc_d  = bias;
                    idx_d  = '0;
                    if (n_start == '0) begin
                        // Empty sum: the result is the bias itself.
                        y_d     = bias;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                req_valid = 1'b1;
                req_idx   = idx_q;
                if (resp_valid) begin
                    w_d     = w_in;
                    x_d     = x_in;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                alu_en     = 1'b1;
                alu_op_sel = OP_MUL;
                alu_op1    = w_q;
                alu_op2    = x_q;
                prod_d     = alu_result;
                state_d    = S_ACC;
            end
            S_ACC: begin
                alu_en     = 1'b1;
                alu_op_sel = mode_q ? OP_SUB : OP_ADD;
                alu_op1    = acc_q;
                alu_op2    = prod_q;
                acc_d      = alu_result;
                if (last_term) begin
                    // Load y on entry to DONE so it is valid with the pulse.
                    y_d     = alu_result;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ONE_I;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any evaluation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            w_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            w_q     <= w_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Directed bench for alu_mac_sequencer with a behavioural ALU and a
// weight/activation memory whose response latency is set per term.
module tb_alu_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_terms;
    logic [15:0] bias;
    logic        mode;
    logic        busy, done, req_valid, resp_valid, alu_en;
    logic [15:0] y, w_in, x_in, alu_op1, alu_op2, alu_result;
    logic [3:0]  req_idx;
    logic [1:0]  alu_op_sel;

    alu_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
        .bias(bias), .mode(mode), .busy(busy), .done(done), .y(y),
        .req_valid(req_valid), .req_idx(req_idx), .resp_valid(resp_valid),
        .w_in(w_in), .x_in(x_in), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_en(alu_en), .alu_op_sel(alu_op_sel), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // ALU model: add/sub modulo 2^16, multiply keeps the low 16 bits.
    always_comb begin
        case (alu_op_sel)
            2'b00:   alu_result = alu_op1 + alu_op2;
            2'b01:   alu_result = alu_op1 - alu_op2;
            2'b10:   alu_result = alu_op1 * alu_op2;
            default: alu_result = 16'hDEAD;
        endcase
    end

    // Memory model: answers req_idx after dly[req_idx] cycles of waiting.
    logic [15:0] wmem [16];
    logic [15:0] xmem [16];
    int          dly  [16];
    int          wait_cnt = 0;

    assign resp_valid = req_valid && (wait_cnt >= dly[req_idx]);
    assign w_in       = wmem[req_idx];
    assign x_in       = xmem[req_idx];

    always @(posedge clk) wait_cnt <= (req_valid && !resp_valid) ? wait_cnt + 1 : 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-run traces collected by run().
    logic [1:0] op_trace  [64];
    logic [3:0] idx_trace [64];
    int         op_cnt, idx_cnt;
    logic       busy_bad, gate_bad;

    // Issue start (edge 0 samples it) and follow the run until done or timeout.
    // Returns the cycle number of the done pulse (-1 on timeout) and y then.
    task automatic run(input logic [4:0] n, input logic [15:0] b, input logic m,
                       input int pulse_at, output int dcyc, output logic [15:0] yv);
        op_cnt = 0; idx_cnt = 0; busy_bad = 1'b0; gate_bad = 1'b0;
        dcyc = -1; yv = 'x;
        start = 1'b1; num_terms = n; bias = b; mode = m;
        @(posedge clk); #1;
        for (int c = 1; c <= 200 && dcyc < 0; c++) begin
            start = (c == pulse_at);
            @(negedge clk);
            if (alu_en) begin
                op_trace[op_cnt] = alu_op_sel;
                op_cnt++;
            end else if (alu_op_sel != 2'b00 || alu_op1 != 16'h0 || alu_op2 != 16'h0) begin
                gate_bad = 1'b1;
            end
            if (req_valid && resp_valid) begin
                idx_trace[idx_cnt] = req_idx;
                idx_cnt++;
            end
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                dcyc = c;
                yv   = y;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Compare the ALU op and fetch-index traces against n terms in mode m.
    task automatic check_traces(input string tag, input int n, input logic m);
        logic ok_ops, ok_idx;
        ok_ops = (op_cnt == 2 * n);
        ok_idx = (idx_cnt == n);
        for (int i = 0; i < n && ok_ops; i++) begin
            if (op_trace[2*i] != 2'b10) ok_ops = 1'b0;
            if (op_trace[2*i+1] != (m ? 2'b01 : 2'b00)) ok_ops = 1'b0;
        end
        for (int i = 0; i < n && ok_idx; i++)
            if (idx_trace[i] != 4'(i)) ok_idx = 1'b0;
        chk({tag, "_opsel_seq"}, 64'(ok_ops), 64'd1);
        chk({tag, "_reqidx_seq"}, 64'(ok_idx), 64'd1);
        chk({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
        chk({tag, "_alu_gating"}, 64'(gate_bad), 64'd0);
    endtask

    typedef struct packed {
        logic [4:0]       n;
        logic [15:0]      bias;
        logic             mode;
        logic [3:0][15:0] w;
        logic [3:0][15:0] x;
        logic [3:0][7:0]  dly;
        int               pulse_at;
        logic [15:0]      exp_y;
        int               exp_cyc;
    } vec_t;

    vec_t vecs [5];
    int   dcyc, dcyc2;
    logic [15:0] yv, yv2;
    logic saw_done;

    initial begin
        // {n, bias, mode, w[3..0], x[3..0], dly[3..0], pulse_at, exp_y, exp_cyc}
        vecs[0] = '{5'd3, 16'd5, 1'b0, {16'd0, 16'd4, 16'd3, 16'd2},
                    {16'd0, 16'd30, 16'd20, 16'd10}, 32'h0, -1, 16'd205, 10};
        vecs[1] = '{5'd3, 16'd5, 1'b1, {16'd0, 16'd4, 16'd3, 16'd2},
                    {16'd0, 16'd30, 16'd20, 16'd10}, 32'h0, -1, 16'hFF3D, 10};
        vecs[2] = '{5'd0, 16'h1234, 1'b0, 64'h0, 64'h0, 32'h0, -1, 16'h1234, 1};
        vecs[3] = '{5'd2, 16'd100, 1'b0, {16'd0, 16'd0, 16'hFFFF, 16'd3},
                    {16'd0, 16'd0, 16'd2, 16'd4}, {8'd0, 8'd0, 8'd3, 8'd0}, 5, 16'd110, 10};
        vecs[4] = '{5'd1, 16'h7FFF, 1'b1, {48'h0, 16'h0100}, {48'h0, 16'h0100},
                    32'h0, -1, 16'h7FFF, 4};
        for (int i = 0; i < 16; i++) begin
            wmem[i] = 16'h0; xmem[i] = 16'h0; dly[i] = 0;
        end

        // Reset holds everything at zero even with start asserted.
        rst = 1'b1; start = 1'b1; num_terms = 5'd3; bias = 16'hFFFF; mode = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("reset_outputs", {busy, done, y, req_valid, req_idx, alu_en,
                                  alu_op_sel, alu_op1, alu_op2}, 64'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", {busy, done, req_valid, alu_en}, 64'h0);
        @(posedge clk); #1;

        // Table-driven evaluations.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                wmem[i] = vecs[v].w[i];
                xmem[i] = vecs[v].x[i];
                dly[i]  = int'(vecs[v].dly[i]);
            end
            run(vecs[v].n, vecs[v].bias, vecs[v].mode, vecs[v].pulse_at, dcyc, yv);
            chk($sformatf("v%0d_done_cycle", v), 64'(dcyc), 64'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_y", v), 64'(yv), 64'(vecs[v].exp_y));
            check_traces($sformatf("v%0d", v), int'(vecs[v].n), vecs[v].mode);
            @(negedge clk);
            chk($sformatf("v%0d_busy_fall", v), {busy, done, y}, {2'b00, vecs[v].exp_y});
            @(posedge clk); #1;
        end

        // Oversized term count saturates at 16 terms.
        for (int i = 0; i < 16; i++) begin
            wmem[i] = 16'd1; xmem[i] = 16'd2; dly[i] = 0;
        end
        run(5'd31, 16'd3, 1'b0, -1, dcyc, yv);
        chk("clamp_done_cycle", 64'(dcyc), 64'd49);
        chk("clamp_y", 64'(yv), 64'd35);
        check_traces("clamp", 16, 1'b0);
        @(posedge clk); #1;

        // Reset during the second ACC of an N=4 run aborts without done.
        for (int i = 0; i < 4; i++) begin
            wmem[i] = 16'(i + 1); xmem[i] = 16'd1; dly[i] = 0;
        end
        start = 1'b1; num_terms = 5'd4; bias = 16'd9; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_acc2", {alu_en, alu_op_sel, alu_op1, alu_op2}, {1'b1, 2'b00, 16'd10, 16'd2});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {busy, done, y, req_valid, alu_en}, 64'h0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        @(posedge clk); #1;

        // Fresh run after abort, then a start in the cycle right after done.
        wmem[0] = 16'd7; xmem[0] = 16'd6; dly[0] = 0;
        run(5'd1, 16'd1, 1'b0, -1, dcyc, yv);
        chk("post_abort_done_cycle", 64'(dcyc), 64'd4);
        chk("post_abort_y", 64'(yv), 64'd43);
        run(5'd0, 16'hBEEF, 1'b0, -1, dcyc2, yv2);
        chk("b2b_done_cycle", 64'(dcyc2), 64'd1);
        chk("b2b_y", 64'(yv2), 64'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
